// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rst_seq_pkg.sv
// Shared types, default parameters and the lowest-set-bit helper for the reset-release sequencer.
// The helper returns an index, so callers can build a one-hot mask of their own width.
package gf180mcu_fd_sc_mcu9t5v0__rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    localparam int DEF_NBANK    = 4;
    localparam int DEF_HOLD_CYC = 4;
    localparam int DEF_GAP_CYC  = 2;
    localparam int DEF_CW       = 8;

    // Index of the lowest set bit of v; 0 when v is all zeros.
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        lowest_set = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) lowest_set = 4'(i);
        end
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rst_seq_if.sv
// Request/status bundle between block-level control (master) and the sequencer (slave).
// Port-level names follow the sequencer's pin names.
interface gf180mcu_fd_sc_mcu9t5v0__rst_seq_if
    import gf180mcu_fd_sc_mcu9t5v0__rst_seq_pkg::*;
#(
    parameter int NBANK = DEF_NBANK
);
    logic             REQ;
    logic [NBANK-1:0] BANK_MASK;
    logic [NBANK-1:0] RN_BANK;
    logic             BUSY;
    logic             ACK;
    logic             ERR;

    modport master (output REQ, BANK_MASK, input RN_BANK, BUSY, ACK, ERR);
    modport slave  (input REQ, BANK_MASK, output RN_BANK, BUSY, ACK, ERR);
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rst_seq_cnt.sv
// Loadable down-counter with zero flag, shared by the hold and gap phases.
// Load wins over decrement; decrement saturates at zero.
module gf180mcu_fd_sc_mcu9t5v0__rst_seq_cnt #(
    parameter int          CW      = 8,
    parameter logic [CW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rn,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rn) cnt_q <= RST_VAL;
        else     cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rst_seq.sv
// Reset-release sequencer: holds masked banks low, then releases them one per gap in ascending order.
// Optional sticky ERR (REQ while BUSY) is built only when RST_SEQ_ERR_EN is defined.
module gf180mcu_fd_sc_mcu9t5v0__rst_seq
    import gf180mcu_fd_sc_mcu9t5v0__rst_seq_pkg::*;
#(
    parameter int NBANK    = DEF_NBANK,
    parameter int HOLD_CYC = DEF_HOLD_CYC,
    parameter int GAP_CYC  = DEF_GAP_CYC,
    parameter int CW       = DEF_CW
) (
    input logic CLK,
    input logic RN,
    gf180mcu_fd_sc_mcu9t5v0__rst_seq_if.slave bus
);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYC - 1);

    state_e           state_q, state_d;
    logic [NBANK-1:0] rn_bank_q, rn_bank_d;
    logic [NBANK-1:0] pend_q, pend_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             por_q, por_d;

    logic             cnt_load;
    logic [CW-1:0]    cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;

    logic [15:0]      pend_ext;
    logic [3:0]       low_idx;
    logic [NBANK-1:0] rel_oh;

    gf180mcu_fd_sc_mcu9t5v0__rst_seq_cnt #(
        .CW      (CW),
        .RST_VAL (HOLD_LD)
    ) u_cnt (
        .clk      (CLK),
        .rn       (RN),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        pend_ext = '0;
        pend_ext[NBANK-1:0] = pend_q;
    end

    assign low_idx = lowest_set(pend_ext);
    assign rel_oh  = NBANK'(1) << low_idx;

    always_ff @(posedge CLK) begin
        if (!RN) begin
            state_q   <= ST_ASSERT;
            rn_bank_q <= '0;
            pend_q    <= '1;
            busy_q    <= 1'b1;
            ack_q     <= 1'b0;
            por_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            rn_bank_q <= rn_bank_d;
            pend_q    <= pend_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            por_q     <= por_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (bus.REQ && (bus.BANK_MASK != '0)) state_d = ST_ASSERT;
            ST_ASSERT:  if (cnt_zero) state_d = ST_RELEASE;
            ST_RELEASE: if (cnt_zero && (pend_q == '0)) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rn_bank_d    = rn_bank_q;
        pend_d       = pend_q;
        busy_d       = busy_q;
        ack_d        = 1'b0;
        por_d        = por_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.REQ) begin
                    if (bus.BANK_MASK != '0) begin
                        pend_d       = bus.BANK_MASK;
                        rn_bank_d    = rn_bank_q & ~bus.BANK_MASK;
                        busy_d       = 1'b1;
                        cnt_load     = 1'b1;
                        cnt_load_val = HOLD_LD;
                    end else begin
                        ack_d = 1'b1;
                    end
                end
            end
            ST_ASSERT, ST_RELEASE: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (pend_q != '0) begin
                    // ASSERT always has a pending bank, so both states share this release path.
                    rn_bank_d    = rn_bank_q | rel_oh;
                    pend_d       = pend_q & ~rel_oh;
                    cnt_load     = 1'b1;
                    cnt_load_val = GAP_LD;
                end else begin
                    busy_d = 1'b0;
                    ack_d  = ~por_q;
                    por_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign bus.RN_BANK = rn_bank_q;
    assign bus.BUSY    = busy_q;
    assign bus.ACK     = ack_q;

`ifdef RST_SEQ_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (bus.REQ & busy_q);
    end

    always_ff @(posedge CLK) begin
        if (!RN) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign bus.ERR = err_q;
`else
    assign bus.ERR = 1'b0;
`endif

endmodule
